// File: rtl/spi_master_pkg.sv
// spi_pkg: shared frame geometry, master FSM state type and frame packing
// helper for the SPI register-access master.
package spi_pkg;

  localparam int unsigned SPI_FRAME_BITS = 16;
  localparam int unsigned SPI_ADDR_BITS  = 4;
  localparam int unsigned SPI_DATA_BITS  = 8;
  localparam int unsigned SPI_PAD_BITS   = 3;

  typedef enum logic [2:0] {
    FLUSH_H,
    FLUSH_L,
    IDLE,
    SETUP,
    HIGH,
    LOW,
    FIN
  } spi_mstate_t;

  // {rnw, addr, pad, data}; the data field is all zeros on a read.
  function automatic logic [SPI_FRAME_BITS-1:0] spi_frame(
    input logic                     rnw,
    input logic [SPI_ADDR_BITS-1:0] addr,
    input logic [SPI_DATA_BITS-1:0] data
  );
    return {rnw, addr, {SPI_PAD_BITS{1'b0}},
            (rnw ? {SPI_DATA_BITS{1'b0}} : data)};
  endfunction

endpackage

// File: rtl/spi_master_phase_timer.sv
// spi_phase_timer: phase-length down-counter for the SPI master FSM.
//   clk    in  system clock
//   reset  in  synchronous active-high reset (acts as a load)
//   load   in  reload to CLKDIV-1; asserted on every FSM state change
//   expire out high in the last cycle of the current phase
module spi_phase_timer #(
  parameter int unsigned CLKDIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expire
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      r_cnt <= 8'(CLKDIV - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign expire = (r_cnt == '0);

endmodule

// File: rtl/spi_master.sv
// spi_master: issues 16-bit register-access SPI frames (rnw, addr, pad, data)
// from a one-cycle parallel request and returns read data in parallel.
//   clk, reset       system clock, synchronous active-high reset
//   start            request strobe, accepted only while busy=0
//   rnw/addr/wrdata  request fields, sampled with start
//   busy             high from accept (or reset) until frame end
//   done             one-cycle pulse at frame end
//   rddata           data from the last completed read
//   spiclk/spien/spidout  SCLK (idles low), active-high select, MOSI
//   spidin           MISO, asynchronous, synchronized internally
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLKDIV = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     rnw,
  input  logic [SPI_ADDR_BITS-1:0] addr,
  input  logic [SPI_DATA_BITS-1:0] wrdata,
  output logic                     busy,
  output logic                     done,
  output logic [SPI_DATA_BITS-1:0] rddata,
  output logic                     spiclk,
  output logic                     spien,
  output logic                     spidout,
  input  logic                     spidin
);

  spi_mstate_t               r_state;
  logic [SPI_FRAME_BITS-1:0] r_shift;
  logic [4:0]                r_bitcnt;
  logic [1:0]                r_sync;
  logic [SPI_DATA_BITS-1:0]  r_cap;
  logic [SPI_DATA_BITS-1:0]  r_rddata;
  logic                      r_rnw;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_spiclk;
  logic                      r_spien;
  logic                      r_spidout;

  logic                      w_expire;
  logic                      w_load;
  logic [SPI_FRAME_BITS-1:0] w_frame;

  assign w_frame = spi_frame(rnw, addr, wrdata);

  // Reload the phase timer on every transition so each timed state lasts
  // exactly CLKDIV cycles.
  always_comb begin
    w_load = 1'b0;
    case (r_state)
      FLUSH_H, FLUSH_L, SETUP, HIGH, LOW: w_load = w_expire;
      IDLE:                               w_load = start;
      default:                            w_load = 1'b0;
    endcase
  end

  spi_phase_timer #(.CLKDIV(CLKDIV)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (w_load),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], spidin};
    end
  end

  // Outputs are registered with the value belonging to the state being
  // entered, so they change on the same edge as r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FLUSH_H;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_cap     <= '0;
      r_rddata  <= '0;
      r_rnw     <= 1'b0;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
      r_spiclk  <= 1'b0;
      r_spien   <= 1'b0;
      r_spidout <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        FLUSH_H: begin
          // Clock pulse with select low clears a slave left mid-frame.
          r_spiclk <= 1'b1;
          if (w_expire) begin
            r_spiclk <= 1'b0;
            r_state  <= FLUSH_L;
          end
        end
        FLUSH_L: begin
          if (w_expire) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        IDLE: begin
          if (start) begin
            r_shift   <= w_frame;
            r_rnw     <= rnw;
            r_bitcnt  <= '0;
            r_spien   <= 1'b1;
            r_spidout <= w_frame[SPI_FRAME_BITS-1];
            r_busy    <= 1'b1;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          if (w_expire) begin
            r_spiclk <= 1'b1;
            r_state  <= HIGH;
          end
        end
        HIGH: begin
          if (w_expire) begin
            // High phases 9..16 carry the slave's data byte.
            if (r_bitcnt[3]) begin
              r_cap <= {r_cap[SPI_DATA_BITS-2:0], r_sync[1]};
            end
            r_spiclk  <= 1'b0;
            r_shift   <= r_shift << 1;
            r_spidout <= r_shift[SPI_FRAME_BITS-2];
            r_bitcnt  <= r_bitcnt + 5'd1;
            r_state   <= LOW;
          end
        end
        LOW: begin
          if (w_expire) begin
            if (r_bitcnt == 5'(SPI_FRAME_BITS)) begin
              r_spien <= 1'b0;
              r_done  <= 1'b1;
              if (r_rnw) begin
                r_rddata <= r_cap;
              end
              r_state <= FIN;
            end else begin
              r_spiclk <= 1'b1;
              r_state  <= HIGH;
            end
          end
        end
        FIN: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= FLUSH_H;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rddata  = r_rddata;
  assign spiclk  = r_spiclk;
  assign spien   = r_spien;
  assign spidout = r_spidout;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: runs the SPI master at CLKDIV=4 and CLKDIV=2 side by side.
// Each configuration has a serial slave model, a cycle-level expected-output
// model derived from the frame timing formulas, directed scenarios and a
// randomized phase.
module tb_spi_master;

  int unsigned total = 0;
  int unsigned bad   = 0;
  bit          fin_flag [2];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int cfg, input string name, input int cyc,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL cfg%0d %s at cycle %0d: got 0x%0h expected 0x%0h",
               cfg, name, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int C = (g == 0) ? 4 : 2;

    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rnw = 1'b0;
    logic [3:0] addr = '0;
    logic [7:0] wrdata = '0;
    logic       spidin = 1'b0;
    logic       busy, done, spiclk, spien, spidout;
    logic [7:0] rddata;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    spi_master #(.CLKDIV(C)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .rnw     (rnw),
      .addr    (addr),
      .wrdata  (wrdata),
      .busy    (busy),
      .done    (done),
      .rddata  (rddata),
      .spiclk  (spiclk),
      .spien   (spien),
      .spidout (spidout),
      .spidin  (spidin)
    );

    // Serial slave: samples MOSI on rising edges, drives MISO on falling edges.
    logic [7:0]  s_mem [16];
    logic [15:0] s_sh = '0;
    logic [15:0] s_frame = '0;
    logic [3:0]  s_addr = '0;
    logic [7:0]  s_tmp;
    int          s_cnt = 0;
    int          s_edges = 0;
    int          s_flush = 0;

    always @(posedge spien) begin
      s_cnt = 0;
      s_sh  = '0;
    end
    always @(posedge spiclk) begin
      if (spien) begin
        s_sh = {s_sh[14:0], spidout};
        s_cnt++;
        if (s_cnt == 8) s_addr = s_sh[6:3];
      end else begin
        s_flush++;
      end
    end
    always @(negedge spiclk) begin
      if (spien && s_cnt >= 8 && s_cnt < 16) begin
        s_tmp  = s_mem[s_addr];
        spidin = s_tmp[15-s_cnt];
      end
    end
    always @(negedge spien) begin
      s_frame = s_sh;
      s_edges = s_cnt;
      if (s_cnt == 16 && !s_sh[15]) s_mem[s_sh[14:11]] = s_sh[7:0];
    end

    // Expected outputs from the frame timing: accept at T, select high over
    // T+1..T+33C, clock high in [C+2Cj, 2C+2Cj) after T+1, FIN at T+1+33C.
    logic [7:0] m_mem [16];
    bit         m_valid = 1'b0;
    bit         m_inframe = 1'b0;
    bit         m_rnw = 1'b0;
    int         m_T = 0, m_R = 0, m_frame = 0, m_addr = 0, m_wd = 0;
    logic [7:0] m_rd = '0;
    logic [7:0] m_exp = '0;

    always @(negedge clk) begin
      int d, ee, k;
      bit e_en, e_clk, e_busy, e_done, e_do;
      e_en = 1'b0; e_clk = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_do = 1'b0;
      if (m_valid) begin
        if (m_inframe) begin
          d = cyc - m_T;
          if (d <= 33*C) begin
            ee     = d - 1;
            e_en   = 1'b1;
            e_busy = 1'b1;
            e_clk  = (ee >= C) && (ee < 32*C) && ((((ee - C) / C) % 2) == 0);
            k      = (ee < 2*C) ? 0 : ((ee - 2*C) / (2*C)) + 1;
            e_do   = (k < 16) ? m_frame[15-k] : 1'b0;
          end else if (d == 33*C + 1) begin
            e_busy = 1'b1;
            e_done = 1'b1;
            if (m_rnw) m_rd = m_exp;
            else       m_mem[m_addr] = 8'(m_wd);
            chk(g, "slave_frame", cyc, 32'(s_frame), m_frame);
            chk(g, "slave_edges", cyc, s_edges, 16);
            if (!m_rnw) chk(g, "slave_wr", cyc, 32'(s_mem[m_addr]), m_wd);
          end
        end else begin
          d      = cyc - m_R;
          e_busy = (d <= 2*C);
          e_clk  = (d >= 2) && (d <= C);
        end
        chk(g, "spien", cyc, 32'(spien), 32'(e_en));
        chk(g, "spiclk", cyc, 32'(spiclk), 32'(e_clk));
        chk(g, "busy", cyc, 32'(busy), 32'(e_busy));
        chk(g, "done", cyc, 32'(done), 32'(e_done));
        chk(g, "rddata", cyc, 32'(rddata), 32'(m_rd));
        if (e_en) chk(g, "spidout", cyc, 32'(spidout), 32'(e_do));
      end
      if (reset) begin
        m_valid   = 1'b1;
        m_inframe = 1'b0;
        m_R       = cyc;
        m_rd      = '0;
      end else if (m_valid && !e_busy && start) begin
        m_inframe = 1'b1;
        m_T       = cyc;
        m_rnw     = rnw;
        m_addr    = int'(addr);
        m_wd      = int'(wrdata);
        m_frame   = (rnw ? 32'h8000 : 32'h0) + (int'(addr) * 2048)
                  + (rnw ? 0 : int'(wrdata));
        m_exp     = m_mem[addr];
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic wait_idle();
      int n = 0;
      while (busy && n < 1000) begin tick(); n++; end
      chk(g, "idle_timeout", cyc, 32'(busy), 32'h0);
    endtask

    task automatic frame(input logic r, input logic [3:0] a,
                         input logic [7:0] w, output int lat);
      int t0, n;
      wait_idle();
      rnw = r; addr = a; wrdata = w; start = 1'b1; t0 = cyc;
      tick();
      start = 1'b0;
      n = 0;
      while (!done && n < 40*C) begin tick(); n++; end
      chk(g, "done_seen", cyc, 32'(done), 32'h1);
      lat = cyc - t0;
    endtask

    initial begin : stim
      int lat, n, dn;
      for (int i = 0; i < 16; i++) s_mem[i] = 8'(i * 37 + 11);
      s_mem[12] = 8'h3C; s_mem[3] = 8'h81; s_mem[1] = 8'hFF; s_mem[2] = 8'h00;
      for (int i = 0; i < 16; i++) m_mem[i] = s_mem[i];

      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      n = cyc; dn = 0;
      while (busy && dn < 1000) begin tick(); dn++; end
      chk(g, "reset_to_idle", cyc, cyc - n, 2*C);

      frame(1'b0, 4'h5, 8'hA3, lat);
      chk(g, "wr_latency", cyc, lat, (g == 0) ? 133 : 67);
      chk(g, "wr_mosi", cyc, 32'(s_frame), 32'h28A3);
      chk(g, "wr_edges", cyc, s_edges, 16);
      chk(g, "wr_mem5", cyc, 32'(s_mem[5]), 32'hA3);

      frame(1'b1, 4'hC, 8'h5A, lat);
      chk(g, "rd_0C", cyc, 32'(rddata), 32'h3C);
      chk(g, "rd_mosi", cyc, 32'(s_frame), 32'hE000);
      frame(1'b0, 4'h7, 8'h55, lat);
      chk(g, "rd_hold", cyc, 32'(rddata), 32'h3C);

      frame(1'b1, 4'h1, 8'h00, lat);
      chk(g, "rd_FF", cyc, 32'(rddata), 32'hFF);
      frame(1'b1, 4'h2, 8'hFF, lat);
      chk(g, "rd_00", cyc, 32'(rddata), 32'h00);
      chk(g, "rd_latency", cyc, lat, (g == 0) ? 133 : 67);

      wait_idle();
      start = 1'b1; rnw = 1'b0; addr = 4'h9; dn = 0;
      for (int i = 0; i < 300; i++) begin
        wrdata = 8'($urandom);
        tick();
        if (done) dn++;
      end
      start = 1'b0;
      chk(g, "busy_frames", cyc, dn, (g == 0) ? 2 : 4);
      wait_idle();

      rnw = 1'b0; addr = 4'hE; wrdata = 8'h99; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (s_cnt != 7 && n < 100*C) begin tick(); n++; end
      chk(g, "edge7_reached", cyc, s_cnt, 7);
      reset = 1'b1; s_flush = 0;
      tick();
      reset = 1'b0;
      chk(g, "abort_spien", cyc, 32'(spien), 32'h0);
      chk(g, "abort_spiclk", cyc, 32'(spiclk), 32'h0);
      wait_idle();
      chk(g, "flush_pulses", cyc, s_flush, 1);
      chk(g, "abort_nowrite", cyc, 32'(s_mem[14]), 32'(m_mem[14]));
      frame(1'b1, 4'h3, 8'h00, lat);
      chk(g, "rd_81", cyc, 32'(rddata), 32'h81);

      for (int i = 0; i < 2500; i++) begin
        start  = ($urandom_range(0, 7) == 0);
        rnw    = 1'($urandom);
        addr   = 4'($urandom);
        wrdata = 8'($urandom);
        reset  = ($urandom_range(0, 799) == 0);
        tick();
      end
      start = 1'b0;
      reset = 1'b0;
      tick();
      wait_idle();
      repeat (3) tick();
      fin_flag[g] = 1'b1;
    end
  end

  initial begin : summary
    int n = 0;
    while (!(fin_flag[0] && fin_flag[1]) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    if (!(fin_flag[0] && fin_flag[1])) begin
      total++;
      bad++;
      $display("FAIL global_timeout: finished cfg0=%0d cfg1=%0d expected 1 1",
               fin_flag[0], fin_flag[1]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Master-side SPI engine that originates the 16-bit register-access frames consumed by our SPI slave (mode bit, 4-bit address, 8-bit data). It sits in the FPGA-side controller and turns a one-cycle parallel request into a framed serial transaction on spien/spiclk/spidout/spidin. It returns read data in parallel and pulses `done` when the frame closes.

## Interface

Parameters:
- `CLKDIV`, default 4, sets the number of `clk` cycles per spiclk half-period. Legal range is 2..255.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request strobe. Accepted only when `busy`=0.
- `rnw`  in  1  1 = read, 0 = write. Sampled with `start`.
- `addr`  in  4  register address. Sampled with `start`.
- `wrdata`  in  8  write data. Sampled with `start`; ignored on reads.
- `busy`  out  1  high from the cycle after an accepted `start` (or after reset) until `done`.
- `done`  out  1  one-cycle pulse at frame end.
- `rddata`  out  8  data captured on the last read. Holds its value until the next read completes.
- `spiclk`  out  1  SCLK. Idles low.
- `spien`  out  1  slave select, active high.
- `spidout`  out  1  MOSI.
- `spidin`  in  1  MISO. Asynchronous input.

## Operation

- Frame format, MSB first, 16 bits: bit15 = `rnw`; bits14:11 = `addr`; bits10:8 = 000; bits7:0 = `wrdata` on a write, 0x00 on a read.
- Bus discipline:
  - The slave samples MOSI on the spiclk rising edge and drives MISO on the falling edge.
  - The master changes `spidout` only while spiclk is low.
- FSM states: FLUSH_H, FLUSH_L, IDLE, SETUP, HIGH, LOW, FIN.
  - Reset → FLUSH_H. FLUSH_H drives spiclk=1 with spien=0 for `CLKDIV` cycles. This clears the slave's bit counter after an aborted frame.
  - FLUSH_H → FLUSH_L, which drives spiclk=0 for `CLKDIV` cycles, then → IDLE.
  - IDLE + `start`: latch the frame into a 16-bit shift register and clear the bit counter → SETUP. SETUP drives spien=1, spiclk=0, `spidout`=bit15, for `CLKDIV` cycles.
  - SETUP → HIGH (spiclk=1, `CLKDIV` cycles) → LOW (spiclk=0, `CLKDIV` cycles).
  - On entry to LOW: shift the frame left and drive the next bit on `spidout`, then increment the bit counter.
  - LOW loops back to HIGH until 16 HIGH phases have completed, then → FIN.
  - FIN lasts 1 cycle: spien=0, `done`=1, `busy` stays 1 during this cycle. → IDLE, where `busy`=0.
- MISO path:
  - `spidin` passes through a 2-flop synchronizer.
  - The synchronized value is sampled in the last `clk` cycle of HIGH phases 9..16, shifting left into an 8-bit capture register.
  - On a read, the capture register is copied to `rddata` in the FIN cycle. `rddata` is unchanged on writes.
- Boundary behaviour:
  - `start` while `busy`=1 is ignored. Nothing is queued.
  - `start` in the same cycle as FIN is ignored. A `start` in the first IDLE cycle is accepted.
  - `reset` mid-frame: on the next cycle spien=0, spiclk=0 and the FSM enters FLUSH_H. `done` is not pulsed.
  - The phase counter counts `CLKDIV`-1 down to 0 and reloads on each state change. There is no wrap ambiguity.

## Timing

- Reset values: spiclk=0, spien=0, `spidout`=0, `done`=0, `rddata`=0x00, `busy`=1 (FLUSH).
  - `busy` falls `2*CLKDIV` cycles after `reset` deasserts.
- `start` accepted at cycle T:
  - spien rises at T+1.
  - First spiclk rising edge at T+1+`CLKDIV`.
  - 16th rising edge at T+1+31*`CLKDIV`.
  - FIN (spien=0, `done`=1) at T+1+33*`CLKDIV`.
  - `busy`=0 at T+2+33*`CLKDIV`.
- Minimum start-to-start spacing is 33*`CLKDIV`+2 cycles.
- MISO margin: data changes on a falling edge and is sampled 2*`CLKDIV`-1 cycles later, after a 2-cycle synchronizer. This is why `CLKDIV` ≥ 2.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure

- Shared package `spi_pkg` holds:
  - `SPI_FRAME_BITS`=16, `SPI_ADDR_BITS`=4, `SPI_DATA_BITS`=8, `SPI_PAD_BITS`=3.
  - The `spi_mstate_t` enum.
  - A `spi_frame()` helper that packs `rnw`, `addr` and `data`.
- Sub-module `spi_phase_timer`: `CLKDIV` down-counter with `load` input and `expire` output. It is reused by the FSM for every timed state.
- The top module holds the FSM, the 16-bit TX shift register, the 5-bit bit counter, the MISO synchronizer and the capture register.

## Test plan

- Write test (`CLKDIV`=4): `start`, rnw=0, addr=0x5, wrdata=0xA3.
  - MOSI sampled at the rising edges is 0_0101_000_10100011, with exactly 16 edges.
  - The slave model sees wrt and wrtdata=0xA3 at addr 0x5.
  - `done` appears at T+133.
- Read test: rnw=1, addr=0xC, slave model rddata=0x3C.
  - MOSI data bits are all 0.
  - `rddata`=0x3C at `done`; `rddata` is unchanged by a following write.
- Busy test: `start` pulsed every cycle for 300 cycles.
  - Exactly 2 frames complete.
  - No spien glitch between frames; spien is low for ≥ 1 cycle in FIN.
- Reset mid-frame: assert `reset` after the 7th rising edge.
  - Next cycle spien=0, then a single spiclk pulse appears with spien=0.
  - A subsequent read of addr 0x3 returns the slave's value 0x81 correctly.
- `CLKDIV`=2: read returning 0xFF, then 0x00.
  - Both captured correctly with the MISO model switching exactly on falling edges.
  - Frame length is 67 cycles.
